// File: rtl/fp_pkg.sv
// Shared floating-point operand types, reused by the operand source and result collectors.
package fp_pkg;

  localparam int FP_WIDTH = 32;

  typedef struct packed {
    logic [FP_WIDTH-1:0] a;
    logic [FP_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of operand pairs. Pointers wrap modulo DEPTH (a power of two);
// occupancy is tracked by a separate counter so full and empty are unambiguous.
module pair_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  operand_pair_t    push_data,
  input  logic             pop,
  output operand_pair_t    head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  operand_pair_t    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push and pop against the registered occupancy.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axis_operand_source.sv
// Buffers single-cycle operand requests and drives them out as two independent
// AXI-Stream channels (A and B). A pair retires once both channels have taken it.
module axis_operand_source
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [DATA_WIDTH-1:0]       a_in,
  input  logic [DATA_WIDTH-1:0]       b_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [DATA_WIDTH-1:0]       m_axis_a_tdata,
  output logic                        m_axis_a_tvalid,
  input  logic                        m_axis_a_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_b_tdata,
  output logic                        m_axis_b_tvalid,
  input  logic                        m_axis_b_tready,
  output logic [$clog2(FIFO_DEPTH):0] count_out,
  output logic                        drop_out,
  output logic                        overflow_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  operand_pair_t    push_pair_s;
  operand_pair_t    head_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic             a_done_r;
  logic             b_done_r;
  logic             a_done_nxt_s;
  logic             b_done_nxt_s;
  logic             a_hs_s;
  logic             b_hs_s;
  logic             retire_s;
  logic             drop_r;
  logic             overflow_r;

  // Pack the incoming request into a pair.
  always_comb begin
    push_pair_s   = '0;
    push_pair_s.a = a_in;
    push_pair_s.b = b_in;
  end

  pair_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (valid_in),
    .push_data (push_pair_s),
    .pop       (retire_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Head data is masked while empty so every output reads 0 out of reset.
  assign m_axis_a_tvalid = !empty_s && !a_done_r;
  assign m_axis_b_tvalid = !empty_s && !b_done_r;
  assign m_axis_a_tdata  = empty_s ? {DATA_WIDTH{1'b0}} : head_s.a;
  assign m_axis_b_tdata  = empty_s ? {DATA_WIDTH{1'b0}} : head_s.b;
  assign ready_out       = !full_s;
  assign count_out       = count_s;
  assign drop_out        = drop_r;
  assign overflow_out    = overflow_r;

  // Handshake detection, retire decision and next value of the per-channel done flags.
  always_comb begin
    a_hs_s       = m_axis_a_tvalid && m_axis_a_tready;
    b_hs_s       = m_axis_b_tvalid && m_axis_b_tready;
    retire_s     = (a_hs_s && (b_hs_s || b_done_r)) || (b_hs_s && a_done_r);
    a_done_nxt_s = a_done_r;
    b_done_nxt_s = b_done_r;
    if (retire_s) begin
      a_done_nxt_s = 1'b0;
      b_done_nxt_s = 1'b0;
    end else begin
      if (a_hs_s) begin
        a_done_nxt_s = 1'b1;
      end else begin
        a_done_nxt_s = a_done_r;
      end
      if (b_hs_s) begin
        b_done_nxt_s = 1'b1;
      end else begin
        b_done_nxt_s = b_done_r;
      end
    end
  end

  // Done flags remember which channel already delivered the current head.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_done_r <= 1'b0;
      b_done_r <= 1'b0;
    end else begin
      a_done_r <= a_done_nxt_s;
      b_done_r <= b_done_nxt_s;
    end
  end

  // Rejected-push pulse and its sticky record; a same-cycle retire does not free a slot.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      drop_r     <= valid_in && full_s;
      overflow_r <= overflow_r || (valid_in && full_s);
    end
  end

endmodule

// File: tb/tb_axis_operand_source.sv
// Bench for axis_operand_source: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the pair stream.
module tb_axis_operand_source;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk_in   = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [DW-1:0] a_in     = '0;
  logic [DW-1:0] b_in     = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [DW-1:0] m_axis_a_tdata;
  logic          m_axis_a_tvalid;
  logic          m_axis_a_tready = 1'b0;
  logic [DW-1:0] m_axis_b_tdata;
  logic          m_axis_b_tvalid;
  logic          m_axis_b_tready = 1'b0;
  logic [CW-1:0] count_out;
  logic          drop_out;
  logic          overflow_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of pending pairs, which halves of the head were delivered.
  logic [63:0] mq[$];
  bit          m_a_sent = 1'b0;
  bit          m_b_sent = 1'b0;
  bit          m_drop   = 1'b0;
  bit          m_ovf    = 1'b0;

  axis_operand_source #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .a_in            (a_in),
    .b_in            (b_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .m_axis_a_tdata  (m_axis_a_tdata),
    .m_axis_a_tvalid (m_axis_a_tvalid),
    .m_axis_a_tready (m_axis_a_tready),
    .m_axis_b_tdata  (m_axis_b_tdata),
    .m_axis_b_tvalid (m_axis_b_tvalid),
    .m_axis_b_tready (m_axis_b_tready),
    .count_out       (count_out),
    .drop_out        (drop_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output with what the model says should be visible now.
  task automatic check_outputs();
    bit          ne;
    logic [63:0] head;
    ne   = (mq.size() > 0);
    head = ne ? mq[0] : 64'd0;
    check_eq("count",    64'(count_out),       64'(mq.size()));
    check_eq("ready",    64'(ready_out),       64'(mq.size() < DEPTH));
    check_eq("a_tvalid", 64'(m_axis_a_tvalid), 64'(ne && !m_a_sent));
    check_eq("b_tvalid", 64'(m_axis_b_tvalid), 64'(ne && !m_b_sent));
    check_eq("a_tdata",  64'(m_axis_a_tdata),  {32'd0, head[63:32]});
    check_eq("b_tdata",  64'(m_axis_b_tdata),  {32'd0, head[31:0]});
    check_eq("drop",     64'(drop_out),        64'(m_drop));
    check_eq("overflow", 64'(overflow_out),    64'(m_ovf));
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit ne, hs_a, hs_b, was_full, a_n, b_n;
    ne       = (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    hs_a     = ne && !m_a_sent && m_axis_a_tready;
    hs_b     = ne && !m_b_sent && m_axis_b_tready;
    a_n      = m_a_sent || hs_a;
    b_n      = m_b_sent || hs_b;
    if (a_n && b_n) begin
      void'(mq.pop_front());
      m_a_sent = 1'b0;
      m_b_sent = 1'b0;
    end else begin
      m_a_sent = a_n;
      m_b_sent = b_n;
    end
    if (valid_in && !was_full) begin
      mq.push_back({a_in, b_in});
    end
    m_drop = valid_in && was_full;
    m_ovf  = m_ovf || m_drop;
  endtask

  // One clock cycle: drive inputs just after the edge, check on the falling edge.
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] b,
                     input bit ar, input bit br);
    valid_in        = v;
    a_in            = a;
    b_in            = b;
    m_axis_a_tready = ar;
    m_axis_b_tready = br;
    @(negedge clk_in);
    check_outputs();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic mid_reset();
    #2;
    valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check_eq("rst_count",    64'(count_out),       64'd0);
    check_eq("rst_a_tvalid", 64'(m_axis_a_tvalid), 64'd0);
    check_eq("rst_b_tvalid", 64'(m_axis_b_tvalid), 64'd0);
    check_eq("rst_a_tdata",  64'(m_axis_a_tdata),  64'd0);
    check_eq("rst_b_tdata",  64'(m_axis_b_tdata),  64'd0);
    check_eq("rst_drop",     64'(drop_out),        64'd0);
    check_eq("rst_overflow", 64'(overflow_out),    64'd0);
    mq.delete();
    m_a_sent = 1'b0;
    m_b_sent = 1'b0;
    m_drop   = 1'b0;
    m_ovf    = 1'b0;
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Single pair with both channels ready.
    cyc(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Skewed readiness: A takes it in cycle 1, B only in cycle 5.
    cyc(1'b1, 32'hAAAA_0001, 32'hBBBB_0001, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Back-to-back pushes with both channels ready.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1000_0000 + i, 32'h2000_0000 + i, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Overflow: five pushes into a stalled FIFO, then drain.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h5000_0000 + i, 32'h6000_0000 + i, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Push while full coinciding with a retire: push dropped, count falls to 3.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h7000_0000 + i, 32'h8000_0000 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Reset with three pairs queued; nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h9000_0000 + i, 32'h9100_0000 + i, 1'b0, 1'b0);
    mid_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 55), $urandom, $urandom,
          ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 65));
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_operand_source.md
# axis_operand_source

AXI-Stream initiator that feeds operand pairs into the floating-point pipeline (the multipliers' `s_axis_a` / `s_axis_b` ports). It accepts single-cycle operand requests from control logic, such as the manta register bank or a trigger counter. It buffers them in a small FIFO and drives both operand streams with full tvalid/tready compliance, so no request is lost while a slave withholds tready.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: width of each operand.
- `FIFO_DEPTH`, 4: number of buffered operand pairs; a power of two, at least 2.

**Ports**
- `clk_in`  in  1: system clock.
- `rst_n_in`  in  1: reset; asynchronous, active-low.
- `a_in`  in  DATA_WIDTH: operand A of the request.
- `b_in`  in  DATA_WIDTH: operand B of the request.
- `valid_in`  in  1: one-cycle push of {a_in, b_in}.
- `ready_out`  out  1: FIFO not full; a push is accepted this cycle.
- `m_axis_a_tdata`  out  DATA_WIDTH: operand A stream data.
- `m_axis_a_tvalid`  out  1: operand A stream valid.
- `m_axis_a_tready`  in  1: operand A stream ready.
- `m_axis_b_tdata`  out  DATA_WIDTH: operand B stream data.
- `m_axis_b_tvalid`  out  1: operand B stream valid.
- `m_axis_b_tready`  in  1: operand B stream ready.
- `count_out`  out  $clog2(FIFO_DEPTH)+1: number of pairs held, including the head.
- `drop_out`  out  1: one-cycle pulse when a push is rejected.
- `overflow_out`  out  1: sticky drop flag; cleared only by reset.

## Operation

**Storage**
- FIFO of {a, b} pairs with read and write pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
- `count_out` is a separate counter.
- `full` = (count == FIFO_DEPTH). `empty` = (count == 0).

**Push**
- When `valid_in` && !full, write at wr_ptr and advance wr_ptr.
- When `valid_in` && full, drop the request, pulse `drop_out` and set `overflow_out`.
- `ready_out` = !full, computed from the registered count.
- A pop in the same cycle does not rescue a push while full.

**Head presentation**
- Both channels present the pair at rd_ptr.
- `m_axis_a_tvalid` = !empty && !a_done.
- `m_axis_b_tvalid` = !empty && !b_done.

**Per-channel completion flags `a_done` / `b_done`**
- A flag sets on its channel's handshake (tvalid && tready) when the other channel is not yet done and not handshaking this cycle.
- The pair retires when both channels are complete: both handshake in the same cycle, or one handshakes while the other's flag is already set.
- On retire: pop (advance rd_ptr, decrement count) and clear both flags.
- The channels are independent. Neither channel waits for the other's tready before asserting tvalid.

**AXI rules, mandatory**
- Once a channel asserts tvalid, it holds tvalid and its tdata stable until that channel's handshake.
- A channel never re-presents a head it has already delivered.

**Simultaneous push and retire**
- Both take effect; count is unchanged.
- When empty, a push is never visible on the same cycle: no fall-through.

**Reset (`rst_n_in` low, asynchronous)**
- Pointers, count and done flags clear; `overflow_out` clears.
- All outputs go to 0, including tdata.
- Reset mid-transfer discards all buffered pairs and any partially delivered pair. A channel's tvalid dropping here is permitted, because the slaves share the reset.

## Timing

- Push at edge N into an empty FIFO: both tvalids are high after edge N, i.e. in cycle N+1. Latency is 1 cycle.
- Sustained throughput is 1 pair/cycle when both treadys stay high.
- When a channel handshakes early, its tvalid is low from the next cycle until the pair retires.
- The next head appears on the cycle after the retire edge.
- `drop_out` is high for exactly the cycle after the rejected push edge.
- `count_out` updates on the push/retire edge.
- Every output is registered or derived from registered state only; there are no combinational paths from tready to tvalid/tdata.
- Exception: tdata is read from the FIFO memory at the registered rd_ptr.

## Structure

- Shared package `fp_pkg`:
  - `FP_WIDTH` = 32.
  - `typedef struct packed { logic [FP_WIDTH-1:0] a, b; } operand_pair_t`.
  - These are reused by future result collectors.
- Sub-module `pair_fifo`: a synchronous FIFO of `operand_pair_t` with push/pop/full/empty/count.
- The top of this block holds the done flags, retire logic and overflow flag.

## Test plan

1. **Reset:** assert `rst_n_in` low mid-cycle with 3 pairs queued -> all outputs 0 immediately, `count_out`=0, and queued pairs are never emitted after release.
2. **Single pair, both ready:** push {0x3F800000, 0x40000000} -> both tvalids high in the next cycle with that data, retire in the same cycle, `count_out` returns to 0.
3. **Skewed ready:** push pair P; A ready at cycle 1, B ready only at cycle 5:
   - A tvalid falls after cycle 1;
   - B holds tvalid and data stable through cycle 5;
   - `count_out` stays 1 until retire.
4. **Back-to-back:** push 4 pairs on consecutive cycles with both ready -> 4 transfers on consecutive cycles, in order.
5. **Overflow:** both treadys low, push 5 pairs with FIFO_DEPTH=4:
   - `ready_out` falls after the 4th push;
   - the 5th push gives a 1-cycle `drop_out` and `overflow_out` stays 1;
   - draining yields exactly pairs 1-4.
6. **Simultaneous push and retire at full:** the push is dropped and the retire completes -> `count_out`=3.
